// File: rtl/finder_pkg.sv
// Shared types and defaults for the ALU dispatch stage and its execute-stage neighbours.
// Provides the default datapath sizing, the 3-bit opcode set, the packed lane vector and
// the dispatch FSM state encoding. Imported by alu_dispatch and dispatch_timer.
package finder_pkg;

  localparam int DEFAULT_N       = 32;   // operand/result word width
  localparam int DEFAULT_Q       = 16;   // fractional bits of the fixed-point format
  localparam int DEFAULT_ALU_NUM = 8;    // number of execute lanes

  // Opcodes understood by the execute stage; dispatch only forwards them.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MAC = 3'd3,
    OP_MIN = 3'd4,
    OP_MAX = 3'd5,
    OP_ABS = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef logic signed [DEFAULT_ALU_NUM-1:0][DEFAULT_N-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/dispatch_timer.sv
// Timeout counter for the dispatch WAIT state.
// Ports: clk/rst (sync, active-high); clr zeroes the count; en advances it by one;
// expired is high in the enabled cycle whose increment would reach TIMEOUT.
module dispatch_timer
  import finder_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // Flag one cycle early so the FSM leaves WAIT exactly as the count reaches TIMEOUT.
  assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage feeding the multi-lane fixed-point execute stage: accepts one vector command,
// drives lane enables/opcode/operands, waits for all-lanes-done and holds the result for a
// downstream valid/ready consumer. Optional WAIT timeout under `ALU_DISPATCH_TIMEOUT_EN.
// Ports: cmd_* (command handshake in), enable_alu/instr/dataA/dataB (to execute),
// exe_valid/exe_data (from execute), res_* (result handshake out). clk, rst (sync, active-high).
module alu_dispatch
  import finder_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int Q       = DEFAULT_Q,
  parameter int ALU_NUM = DEFAULT_ALU_NUM,
  parameter int TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_instr,
  input  logic [ALU_NUM-1:0]                cmd_mask,
  input  logic signed [ALU_NUM-1:0][N-1:0]  cmd_dataA,
  input  logic signed [ALU_NUM-1:0][N-1:0]  cmd_dataB,
  output logic [ALU_NUM-1:0]                enable_alu,
  output logic [2:0]                        instr,
  output logic signed [ALU_NUM-1:0][N-1:0]  dataA,
  output logic signed [ALU_NUM-1:0][N-1:0]  dataB,
  input  logic                              exe_valid,
  input  logic signed [ALU_NUM-1:0][N-1:0]  exe_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [ALU_NUM-1:0][N-1:0]  res_data,
  output logic [ALU_NUM-1:0]                res_mask,
  output logic                              res_err
);

  // Elaboration-time sanity checks on the configuration.
  if (Q >= N) begin : g_bad_q
    $error("alu_dispatch: Q must be smaller than N");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_dispatch: TIMEOUT must be at least 1");
  end

  dispatch_state_e      state;
  logic [ALU_NUM-1:0]   mask_q;
  logic                 timed_out;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  // Counter is cleared during ISSUE so it starts at zero on the first WAIT cycle;
  // exe_valid gates the enable, so a completion on the expiry cycle wins.
  dispatch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_ISSUE),
    .en      ((state == ST_WAIT) && !exe_valid),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // Held low through the reset cycle itself, then follows IDLE.
  assign cmd_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask_q     <= '0;
      enable_alu <= '0;
      instr      <= '0;
      dataA      <= '0;
      dataB      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_mask   <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            instr  <= cmd_instr;
            dataA  <= cmd_dataA;
            dataB  <= cmd_dataB;
            mask_q <= cmd_mask;
            if (cmd_mask != '0) begin
              enable_alu <= cmd_mask;
              state      <= ST_ISSUE;
            end else begin
              // Nothing to execute: answer immediately with an empty result.
              res_valid <= 1'b1;
              res_data  <= '0;
              res_mask  <= '0;
              res_err   <= 1'b0;
              state     <= ST_RESP;
            end
          end
        end
        // exe_valid here may still belong to the previous command, so it is not looked at.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (exe_valid) begin
            for (int i = 0; i < ALU_NUM; i++) begin
              res_data[i] <= mask_q[i] ? exe_data[i] : '0;
            end
            res_mask   <= mask_q;
            res_err    <= 1'b0;
            res_valid  <= 1'b1;
            enable_alu <= '0;
            state      <= ST_RESP;
          end else if (timed_out) begin
            res_data   <= '0;
            res_mask   <= mask_q;
            res_err    <= 1'b1;
            res_valid  <= 1'b1;
            enable_alu <= '0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch; timeout scenarios run when
// ALU_DISPATCH_TIMEOUT_EN is defined (DUT built with TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_alu_dispatch;
  localparam int N       = 32;
  localparam int ALU_NUM = 8;
  localparam int TO      = 16;

  typedef logic [ALU_NUM-1:0][N-1:0] vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_instr;
  logic [ALU_NUM-1:0] cmd_mask;
  vec_t               cmd_dataA, cmd_dataB;
  logic [ALU_NUM-1:0] enable_alu;
  logic [2:0]         instr;
  vec_t               dataA, dataB;
  logic               exe_valid;
  vec_t               exe_data;
  logic               res_valid;
  logic               res_ready;
  vec_t               res_data;
  logic [ALU_NUM-1:0] res_mask;
  logic               res_err;

  int checks   = 0;
  int failures = 0;

  alu_dispatch #(.N(N), .Q(16), .ALU_NUM(ALU_NUM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr), .cmd_mask(cmd_mask),
    .cmd_dataA(cmd_dataA), .cmd_dataB(cmd_dataB),
    .enable_alu(enable_alu), .instr(instr), .dataA(dataA), .dataB(dataB),
    .exe_valid(exe_valid), .exe_data(exe_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_mask(res_mask), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic vec_t ramp(input logic [31:0] base, input logic [31:0] step);
    vec_t v;
    for (int i = 0; i < ALU_NUM; i++) v[i] = base + step * i;
    return v;
  endfunction

  function automatic vec_t masked(input vec_t v, input logic [ALU_NUM-1:0] m);
    vec_t r;
    for (int i = 0; i < ALU_NUM; i++) r[i] = m[i] ? v[i] : '0;
    return r;
  endfunction

  // Valid while rst is still high after at least one edge.
  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_enable"},    32'(enable_alu), 0);
    chk({tag, "_instr"},     32'(instr), 0);
    chkv({tag, "_dataA"},    dataA, '0);
    chkv({tag, "_dataB"},    dataB, '0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chkv({tag, "_res_data"}, res_data, '0);
    chk({tag, "_res_mask"},  32'(res_mask), 0);
    chk({tag, "_res_err"},   32'(res_err), 0);
  endtask

  // Present a command; returns after the accepting edge (first ISSUE cycle).
  task automatic send(input logic [2:0] op, input logic [ALU_NUM-1:0] m, input vec_t a, input vec_t b);
    cmd_instr = op; cmd_mask = m; cmd_dataA = a; cmd_dataB = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic release_res(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_rv_drop"}, 32'(res_valid), 0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    vec_t a, b, ex, ex2, expv;
    rst = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; cmd_mask = '0;
    cmd_dataA = '0; cmd_dataB = '0; exe_valid = 1'b0; exe_data = '0; res_ready = 1'b0;
    tick(); tick();
    check_reset("rst0");
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // Full mask, minimum latency completion.
    a = ramp(32'h0001_0000, 0); b = a;
    ex = ramp(32'h0001_0000, 32'h0000_0100);
    exe_data = ex;
    send(3'd3, 8'hFF, a, b);
    chk("t1_en_issue", 32'(enable_alu), 32'hFF);
    chk("t1_instr", 32'(instr), 3);
    chkv("t1_dataA", dataA, a);
    chk("t1_busy", 32'(cmd_ready), 0);
    tick();
    chk("t1_en_wait", 32'(enable_alu), 32'hFF);
    chk("t1_rv_early", 32'(res_valid), 0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    chk("t1_rv", 32'(res_valid), 1);
    chkv("t1_data", res_data, ex);
    chk("t1_mask", 32'(res_mask), 32'hFF);
    chk("t1_err", 32'(res_err), 0);
    chk("t1_en_off", 32'(enable_alu), 0);
    release_res("t1");

    // Sparse mask, slow execute, stalled consumer.
    a = ramp(32'hFFFF_0000, 32'h10); b = ramp(32'h0000_8000, 32'h3);
    ex = ramp(32'h1234_0000, 32'h0101);
    exe_data = ex;
    send(3'd1, 8'h05, a, b);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t2_en_held", 32'(enable_alu), 32'h05);
      chkv("t2_dataB_held", dataB, b);
      tick();
    end
    chk("t2_no_rv", 32'(res_valid), 0);
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    exe_data = ramp(32'hDEAD_0000, 1);
    expv = masked(ex, 8'h05);
    for (int k = 0; k < 5; k++) begin
      chk("t2_rv_stall", 32'(res_valid), 1);
      chkv("t2_data_stall", res_data, expv);
      chk("t2_mask_stall", 32'(res_mask), 32'h05);
      chk("t2_err_stall", 32'(res_err), 0);
      chk("t2_ready_stall", 32'(cmd_ready), 0);
      tick();
    end
    release_res("t2");

    // Zero mask: immediate empty response, execute untouched.
    exe_data = ramp(32'h5555_0000, 7);
    send(3'd0, 8'h00, ramp(1, 1), ramp(2, 2));
    chk("t3_rv", 32'(res_valid), 1);
    chkv("t3_data", res_data, '0);
    chk("t3_mask", 32'(res_mask), 0);
    chk("t3_en", 32'(enable_alu), 0);
    release_res("t3");

    // exe_valid stuck high: ISSUE must ignore it, first WAIT cycle captures.
    ex  = ramp(32'h0A0A_0000, 3);
    ex2 = ramp(32'h0B0B_0000, 5);
    exe_valid = 1'b1; exe_data = ex;
    send(3'd2, 8'hF0, ramp(3, 1), ramp(4, 1));
    chk("t4_issue_en", 32'(enable_alu), 32'hF0);
    exe_data = ex;
    tick();
    chk("t4_no_rv_issue", 32'(res_valid), 0);
    exe_data = ex2;
    tick();
    exe_valid = 1'b0;
    chk("t4_rv", 32'(res_valid), 1);
    chkv("t4_data", res_data, masked(ex2, 8'hF0));
    release_res("t4");

    // Reset during WAIT.
    send(3'd4, 8'h3C, ramp(9, 1), ramp(8, 1));
    tick();
    chk("t5_in_wait", 32'(enable_alu), 32'h3C);
    rst = 1'b1;
    tick();
    check_reset("t5_wait_rst");
    rst = 1'b0;
    // Reset during RESP.
    ex = ramp(32'h0000_7777, 32'h11);
    exe_data = ex;
    send(3'd5, 8'h81, ramp(5, 1), ramp(6, 1));
    tick();
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    chk("t5_resp", 32'(res_valid), 1);
    rst = 1'b1;
    tick();
    check_reset("t5_resp_rst");
    rst = 1'b0;
    // Normal command after resets.
    ex = ramp(32'h0C0C_0000, 9);
    exe_data = ex;
    send(3'd6, 8'h42, ramp(7, 1), ramp(7, 2));
    tick();
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    chk("t5_after_rv", 32'(res_valid), 1);
    chkv("t5_after_data", res_data, masked(ex, 8'h42));
    chk("t5_after_mask", 32'(res_mask), 32'h42);
    release_res("t5");

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // No completion: abort after TO WAIT cycles.
    exe_data = ramp(32'h0F0F_0000, 1);
    send(3'd0, 8'h0F, ramp(1, 1), ramp(1, 1));
    for (int k = 0; k < TO; k++) tick();
    chk("t6_rv_before", 32'(res_valid), 0);
    chk("t6_en_before", 32'(enable_alu), 32'h0F);
    tick();
    chk("t6_rv", 32'(res_valid), 1);
    chk("t6_err", 32'(res_err), 1);
    chkv("t6_data", res_data, '0);
    chk("t6_en_off", 32'(enable_alu), 0);
    release_res("t6");
    // Completion on the expiry cycle wins.
    ex = ramp(32'h0E0E_0000, 2);
    exe_data = ex;
    send(3'd0, 8'h0F, ramp(1, 1), ramp(1, 1));
    for (int k = 0; k < TO; k++) tick();
    exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0;
    chk("t7_rv", 32'(res_valid), 1);
    chk("t7_err", 32'(res_err), 0);
    chkv("t7_data", res_data, masked(ex, 8'h0F));
    release_res("t7");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue stage directly upstream of the multi-lane fixed-point execute stage. Accepts one vector command (opcode, lane mask, A/B operands) through a valid/ready handshake. Registers the command and drives the execute stage's lane-enable, opcode and operand inputs, then waits for the all-lanes-done indication. Captures the per-lane results into a one-deep result register offered downstream through a second valid/ready handshake.

## Interface
- `N`, 32, operand/result word width (signed fixed point)
- `Q`, 16, fractional bits; passed through, not used arithmetically here
- `ALU_NUM`, 8, number of lanes
- `TIMEOUT`, 1024, max WAIT cycles before abort (only with timeout feature)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_instr`  in  3  opcode
- `cmd_mask`  in  ALU_NUM  lanes to enable
- `cmd_dataA`, `cmd_dataB`  in  ALU_NUM×N  packed signed operands
- `enable_alu`  out  ALU_NUM  to execute stage
- `instr`  out  3  to execute stage
- `dataA`, `dataB`  out  ALU_NUM×N  to execute stage
- `exe_valid`  in  1  execute stage all-enabled-lanes-done
- `exe_data`  in  ALU_NUM×N  execute stage results
- `res_valid`  out  1  result held
- `res_ready`  in  1  downstream accepts
- `res_data`  out  ALU_NUM×N  results; lanes outside mask are 0
- `res_mask`  out  ALU_NUM  mask of the completed command
- `res_err`  out  1  command aborted by timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `cmd_ready`=1. On handshake, register instr/mask/operands.
  - Mask nonzero: go to ISSUE.
  - Mask zero: go to RESP with `res_data`=0, `res_err`=0; execute is not touched.
- ISSUE (exactly 1 cycle): `enable_alu`=registered mask. `exe_valid` is ignored because it may reflect the previous command. Go to WAIT.
- WAIT: `enable_alu` held. On `exe_valid`=1:
  - capture `exe_data`, zeroing lanes outside the mask;
  - set `res_err`=0;
  - go to RESP.
- RESP: `enable_alu`=0, `res_valid`=1. On `res_ready`, go to IDLE.
- `instr`, `dataA`, `dataB` change only on command accept. They are stable whenever `enable_alu`≠0.
- `cmd_ready`=1 only in IDLE. There is no overlap: at most one command is in flight.
- `res_*` outputs are stable while `res_valid`=1 and `res_ready`=0.

## Timing
- Reset values:
  - state IDLE;
  - `cmd_ready`=0 during the reset cycle, 1 afterwards;
  - `enable_alu`=0, `instr`=0, `dataA`=0, `dataB`=0;
  - `res_valid`=0, `res_data`=0, `res_mask`=0, `res_err`=0.
- Accept at cycle t.
  - `enable_alu` is high from t+1 (ISSUE).
  - The earliest `exe_valid` sample is t+2.
  - `res_valid` rises the cycle after `exe_valid` is sampled. Minimum accept-to-`res_valid` latency is 3 cycles.
- Zero-mask command: `res_valid` at t+1.
- `res_valid` & `res_ready` in RESP: back to IDLE. The next command can be accepted the cycle after. Throughput is at most one command per 4 cycles.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. An in-flight command is dropped and the execute stage sees enable fall.

## Configuration
- `ALU_DISPATCH_TIMEOUT_EN` defined:
  - a counter of width $clog2(TIMEOUT+1) clears on entering WAIT and increments each WAIT cycle without `exe_valid`;
  - when it reaches TIMEOUT, go to RESP with `res_err`=1 and `res_data`=0;
  - `exe_valid` in the same cycle as expiry wins (normal completion).
- Not defined: no counter, WAIT is unbounded, `res_err` is tied 0.

## Structure
- Shared package `finder_pkg`:
  - `N`, `Q`, `ALU_NUM` default constants;
  - opcode enum (3-bit);
  - lane-vector typedef `logic signed [ALU_NUM-1:0][N-1:0]`;
  - dispatch state enum.
- One natural sub-module: `dispatch_timer`, the timeout counter with clear/enable/expired. It is instantiated only under the macro.

## Test plan
- Reset, then mask=8'hFF, instr=3, A=B=32'h0001_0000; model exe_valid at t+2 → enable_alu=FF at t+1..t+2, res_valid at t+3, res_data = model results, res_err=0.
- mask=8'h05, exe_valid delayed 10 cycles, res_ready low 5 cycles → res_data lanes 1,3-7 = 0; all res_* stable while stalled; cmd_ready=0 until release.
- mask=0 → res_valid at t+1, res_data=0, enable_alu never nonzero.
- exe_valid forced 1 during ISSUE and WAIT → result captured at the first WAIT cycle (t+2 sample), not during ISSUE.
- rst asserted in WAIT and in RESP → next cycle all outputs at reset values; a new command completes normally.
- With macro, TIMEOUT=16, exe_valid never asserted → res_valid with res_err=1, res_data=0 after 16 WAIT cycles. Repeat with exe_valid on the expiry cycle → res_err=0.
